// File: rtl/rgmii_mac_side_if.sv
// rtl/rgmii_mac_side_if.sv - PHY-end RGMII: GMII receive to RGMII toward MAC, MAC RGMII transmit to GMII
module rgmii_mac_side_if #(
   parameter int RXC_DIV_100M = 5,
   parameter int RXC_DIV_10M  = 50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] speed,
   input  logic       link_up,
   input  logic       full_duplex,
   input  logic [7:0] gmii_rxd,
   input  logic       gmii_rx_dv,
   input  logic       gmii_rx_er,
   output logic       gmii_rx_clk_en,
   output logic       rgmii_rxc_1,
   output logic       rgmii_rxc_2,
   output logic [3:0] rgmii_rd_1,
   output logic [3:0] rgmii_rd_2,
   output logic       rgmii_rx_ctl_1,
   output logic       rgmii_rx_ctl_2,
   input  logic       rgmii_txc_1,
   input  logic       rgmii_txc_2,
   input  logic [3:0] rgmii_td_1,
   input  logic [3:0] rgmii_td_2,
   input  logic       rgmii_tx_ctl_1,
   input  logic       rgmii_tx_ctl_2,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic       gmii_tx_clk_en,
   output logic       tx_align_err
);

   localparam int MAX_DIV = (RXC_DIV_10M > RXC_DIV_100M) ? RXC_DIV_10M : RXC_DIV_100M;
   localparam int CNT_W   = $clog2(MAX_DIV);

   localparam logic [CNT_W-1:0] LAST_100M = CNT_W'(RXC_DIV_100M - 1);
   localparam logic [CNT_W-1:0] LAST_10M  = CNT_W'(RXC_DIV_10M - 1);
   localparam logic [CNT_W-1:0] HALF_100M = CNT_W'(RXC_DIV_100M / 2);
   localparam logic [CNT_W-1:0] HALF_10M  = CNT_W'(RXC_DIV_10M / 2);
   localparam logic             ODD_100M  = (RXC_DIV_100M % 2) != 0;
   localparam logic             ODD_10M   = (RXC_DIV_10M % 2) != 0;

   // RX side state
   logic [1:0]       speed_reg;
   logic [1:0]       speed_nxt;
   logic [1:0]       speed_norm;
   logic             speed_chg;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] cnt_last;
   logic             rx_phase;
   logic             rx_phase_nxt;
   logic [7:0]       rxd_q;
   logic [7:0]       rxd_nxt;
   logic             dv_q;
   logic             dv_nxt;
   logic             er_q;
   logic             er_nxt;

   // RX output next values
   logic [CNT_W-1:0] half;
   logic             odd;
   logic [3:0]       status;
   logic             idle;
   logic [3:0]       nib;
   logic             rxc_1_nxt;
   logic             rxc_2_nxt;
   logic [3:0]       rd_1_nxt;
   logic [3:0]       rd_2_nxt;
   logic             ctl_1_nxt;
   logic             ctl_2_nxt;

   // TX side state
   logic             txc2_prev;
   logic             ctl_low;
   logic             tx_phase;
   logic             tx_frame;
   logic [3:0]       tx_low;
   logic             tx_er_st;
   logic             tx_busy;
   logic             tx_rise;
   logic             rise_er;

   assign speed_norm     = (speed == 2'b11) ? 2'b10 : speed;
   assign cnt_last       = (speed_reg == 2'b01) ? LAST_100M : LAST_10M;
   assign gmii_rx_clk_en = speed_reg[1] | ((cnt == cnt_last) & rx_phase);
   assign tx_busy        = tx_frame | tx_phase;
   assign speed_chg      = gmii_rx_clk_en & ~gmii_rx_dv & ~tx_busy & (speed_norm != speed_reg);
   assign tx_rise        = ~txc2_prev & rgmii_txc_1;
   assign rise_er        = ctl_low ^ rgmii_tx_ctl_1;

   // Next speed, RXC counter, nibble phase and the byte being serialised.
   always_comb begin
      speed_nxt    = speed_reg;
      cnt_nxt      = '0;
      rx_phase_nxt = 1'b0;
      rxd_nxt      = rxd_q;
      dv_nxt       = dv_q;
      er_nxt       = er_q;
      if (gmii_rx_clk_en) begin
         rxd_nxt = gmii_rxd;
         dv_nxt  = gmii_rx_dv;
         er_nxt  = gmii_rx_er;
      end
      if (speed_chg) begin
         speed_nxt = speed_norm;
      end else if (!speed_reg[1]) begin
         if (cnt == cnt_last) begin
            cnt_nxt      = '0;
            rx_phase_nxt = ~rx_phase;
         end else begin
            cnt_nxt      = cnt + CNT_W'(1);
            rx_phase_nxt = rx_phase;
         end
      end
   end

   // RGMII RX pair values for the coming cycle; idle bytes carry in-band status.
   always_comb begin
      half      = (speed_nxt == 2'b01) ? HALF_100M : HALF_10M;
      odd       = (speed_nxt == 2'b01) ? ODD_100M : ODD_10M;
      status    = {full_duplex, speed_nxt, link_up};
      idle      = ~dv_nxt & ~er_nxt;
      nib       = rx_phase_nxt ? rxd_nxt[7:4] : rxd_nxt[3:0];
      rxc_1_nxt = 1'b1;
      rxc_2_nxt = 1'b0;
      rd_1_nxt  = idle ? status : rxd_nxt[3:0];
      rd_2_nxt  = idle ? status : rxd_nxt[7:4];
      ctl_1_nxt = dv_nxt;
      ctl_2_nxt = dv_nxt ^ er_nxt;
      if (!speed_nxt[1]) begin
         rxc_2_nxt = (cnt_nxt < half);
         rxc_1_nxt = (cnt_nxt < half) | (odd & (cnt_nxt == half));
         rd_1_nxt  = idle ? status : nib;
         rd_2_nxt  = rd_1_nxt;
         ctl_1_nxt = rxc_1_nxt ? dv_nxt : (dv_nxt ^ er_nxt);
         ctl_2_nxt = ctl_1_nxt;
      end
   end

   // RX state and registered DDR halves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         speed_reg      <= 2'b10;
         cnt            <= '0;
         rx_phase       <= 1'b0;
         rxd_q          <= 8'h00;
         dv_q           <= 1'b0;
         er_q           <= 1'b0;
         rgmii_rxc_1    <= 1'b1;
         rgmii_rxc_2    <= 1'b0;
         rgmii_rd_1     <= 4'h0;
         rgmii_rd_2     <= 4'h0;
         rgmii_rx_ctl_1 <= 1'b0;
         rgmii_rx_ctl_2 <= 1'b0;
      end else begin
         speed_reg      <= speed_nxt;
         cnt            <= cnt_nxt;
         rx_phase       <= rx_phase_nxt;
         rxd_q          <= rxd_nxt;
         dv_q           <= dv_nxt;
         er_q           <= er_nxt;
         rgmii_rxc_1    <= rxc_1_nxt;
         rgmii_rxc_2    <= rxc_2_nxt;
         rgmii_rd_1     <= rd_1_nxt;
         rgmii_rd_2     <= rd_2_nxt;
         rgmii_rx_ctl_1 <= ctl_1_nxt;
         rgmii_rx_ctl_2 <= ctl_2_nxt;
      end
   end

   // TX decode: DDR byte per clock at 1G, nibble pairs on TXC rises at 10/100.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txc2_prev      <= 1'b0;
         ctl_low        <= 1'b0;
         tx_phase       <= 1'b0;
         tx_frame       <= 1'b0;
         tx_low         <= 4'h0;
         tx_er_st       <= 1'b0;
         gmii_txd       <= 8'h00;
         gmii_tx_en     <= 1'b0;
         gmii_tx_er     <= 1'b0;
         gmii_tx_clk_en <= 1'b0;
         tx_align_err   <= 1'b0;
      end else begin
         txc2_prev      <= rgmii_txc_2;
         gmii_tx_clk_en <= 1'b0;
         tx_align_err   <= 1'b0;
         if (speed_reg[1]) begin
            gmii_txd       <= {rgmii_td_2, rgmii_td_1};
            gmii_tx_en     <= rgmii_tx_ctl_1;
            gmii_tx_er     <= rgmii_tx_ctl_1 ^ rgmii_tx_ctl_2;
            gmii_tx_clk_en <= 1'b1;
            tx_phase       <= 1'b0;
            tx_frame       <= rgmii_tx_ctl_1;
         end else begin
            if (!rgmii_txc_1 && !rgmii_txc_2) begin
               ctl_low <= rgmii_tx_ctl_2;
            end
            if (tx_rise) begin
               tx_frame <= ctl_low;
               if (!ctl_low) begin
                  // A frame ending on a lone low nibble is flagged and closed with tx_en=0.
                  if (tx_phase) begin
                     gmii_txd       <= 8'h00;
                     gmii_tx_en     <= 1'b0;
                     gmii_tx_er     <= 1'b0;
                     gmii_tx_clk_en <= 1'b1;
                     tx_align_err   <= 1'b1;
                  end
                  tx_phase <= 1'b0;
               end else if (!tx_phase) begin
                  tx_low   <= rgmii_td_1;
                  tx_er_st <= rise_er;
                  tx_phase <= 1'b1;
               end else begin
                  gmii_txd       <= {rgmii_td_1, tx_low};
                  gmii_tx_en     <= 1'b1;
                  gmii_tx_er     <= rise_er | tx_er_st;
                  gmii_tx_clk_en <= 1'b1;
                  tx_phase       <= 1'b0;
               end
            end
         end
      end
   end

endmodule
